// File: rtl/disp_scan_mux.sv
// Time-multiplexed scan driver for a common-select BCD/hex display.
// Each refresh tick registers one digit slot with blanking and leading-zero suppression applied.
module disp_scan_mux #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned SRC    = 2,
   parameter int unsigned DIV    = 1,
   localparam int unsigned SW    = (SRC > 1) ? $clog2(SRC) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [SRC*DIGITS*4-1:0]   src_data,
   input  logic [SW-1:0]             src_sel,
   input  logic                      ovr_en,
   input  logic [DIGITS*4-1:0]       ovr_data,
   input  logic [DIGITS-1:0]         blank_mask,
   input  logic                      lz_en,
   output logic [3:0]                out,
   output logic [DIGITS-1:0]         seg_sel,
   output logic                      blank
);

   localparam int unsigned VW = DIGITS * 4;
   localparam int unsigned IW = $clog2(DIGITS);
   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0]     presc;
   logic [IW-1:0]     idx;
   logic              tick_c;
   logic [VW-1:0]     vec_c;
   logic [DIGITS-1:0] zero_from_c;
   logic              zero_acc;
   logic [3:0]        nib_c;
   logic              mask_c;
   logic              lz_c;
   logic              blank_c;

   assign tick_c = (presc == PW'(DIV - 1));

   // Source select; out-of-range selects fall back to source 0, override wins
   always_comb begin
      vec_c = src_data[VW-1:0];
      for (int s = 1; s < int'(SRC); s++) begin
         if (src_sel == SW'(s)) vec_c = src_data[s*VW +: VW];
      end
      if (ovr_en) vec_c = ovr_data;
   end

   // zero_from_c[k]: every nibble from k up to the most significant digit is zero
   always_comb begin
      zero_from_c = '0;
      zero_acc    = 1'b1;
      for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
         zero_acc       = zero_acc & (vec_c[4*k +: 4] == 4'd0);
         zero_from_c[k] = zero_acc;
      end
   end

   // Current slot decode; digit 0 is exempt from leading-zero suppression
   always_comb begin
      nib_c  = 4'd0;
      mask_c = 1'b0;
      lz_c   = 1'b0;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (idx == IW'(k)) begin
            nib_c  = vec_c[4*k +: 4];
            mask_c = blank_mask[k];
            lz_c   = lz_en && (k != 0) && zero_from_c[k];
         end
      end
      blank_c = mask_c | lz_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc   <= '0;
         idx     <= '0;
         out     <= 4'd0;
         seg_sel <= '0;
         blank   <= 1'b1;
      end else begin
         presc <= tick_c ? '0 : presc + PW'(1);
         if (tick_c) begin
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            if (blank_c) begin
               out     <= 4'd0;
               seg_sel <= '0;
               blank   <= 1'b1;
            end else begin
               out     <= nib_c;
               seg_sel <= DIGITS'(1) << idx;
               blank   <= 1'b0;
            end
         end
      end
   end

endmodule
